// File: rtl/tick_divider_prog.sv
// Programmable tick generator: divides clk_2MHz by a loadable divisor into tick, clk_out and wrap strobes.
// Optional TICK_SYNC_CLR_EN adds a synchronous sync_clr input that re-phases the timebase.
module tick_divider_prog #(
    parameter int unsigned CNT_W       = 21,
    parameter int unsigned DIV_DEFAULT = 10000,
    parameter int unsigned WRAP        = 100,
    parameter int unsigned WRAP_W      = 7
) (
    input  logic             clk_2MHz,
    input  logic             reset,
`ifdef TICK_SYNC_CLR_EN
    input  logic             sync_clr,
`endif
    input  logic             en,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_in,
    output logic             tick,
    output logic             clk_out,
    output logic             wrap,
    output logic [CNT_W-1:0] div_q
);

    localparam logic [CNT_W-1:0]  DIV_MIN   = CNT_W'(2);
    localparam logic [CNT_W-1:0]  DIV_RST   = CNT_W'(DIV_DEFAULT);
    localparam logic [WRAP_W-1:0] WRAP_LAST = WRAP_W'(WRAP - 1);

    logic [CNT_W-1:0]  cnt;
    logic [WRAP_W-1:0] wcnt;
    logic [CNT_W-1:0]  div_clamp_c;
    logic              cnt_last_c;

    // Divisors below 2 would make the terminal compare degenerate, so clamp them.
    assign div_clamp_c = (div_in < DIV_MIN) ? DIV_MIN : div_in;
    // ">=" lets a count left above a freshly shrunk divisor terminate at once.
    assign cnt_last_c  = (cnt >= (div_q - CNT_W'(1)));

    always_ff @(posedge clk_2MHz or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            wcnt    <= '0;
            div_q   <= DIV_RST;
            tick    <= 1'b0;
            clk_out <= 1'b0;
            wrap    <= 1'b0;
        end else begin
`ifdef TICK_SYNC_CLR_EN
            if (sync_clr) begin
                cnt     <= '0;
                wcnt    <= '0;
                tick    <= 1'b0;
                clk_out <= 1'b0;
                wrap    <= 1'b0;
            end else
`endif
            if (div_load) begin
                div_q <= div_clamp_c;
                cnt   <= '0;
                tick  <= 1'b0;
                wrap  <= 1'b0;
            end else if (en) begin
                if (cnt_last_c) begin
                    cnt     <= '0;
                    tick    <= 1'b1;
                    clk_out <= ~clk_out;
                    if (wcnt == WRAP_LAST) begin
                        wcnt <= '0;
                        wrap <= 1'b1;
                    end else begin
                        wcnt <= wcnt + WRAP_W'(1);
                        wrap <= 1'b0;
                    end
                end else begin
                    cnt  <= cnt + CNT_W'(1);
                    tick <= 1'b0;
                    wrap <= 1'b0;
                end
            end else begin
                tick <= 1'b0;
                wrap <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tick_divider_prog.sv
// Directed bench for tick_divider_prog with DIV_DEFAULT=5, WRAP=3.
module tb_tick_divider_prog;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned DIV_DEF = 5;
    localparam int unsigned WRAP    = 3;
    localparam int unsigned WRAP_W  = 2;

    logic             clk_2MHz = 1'b0;
    logic             reset;
    logic             en;
    logic             div_load;
    logic [CNT_W-1:0] div_in;
    logic             tick;
    logic             clk_out;
    logic             wrap;
    logic [CNT_W-1:0] div_q;
`ifdef TICK_SYNC_CLR_EN
    logic             sync_clr;
`endif

    int total = 0;
    int bad   = 0;

    tick_divider_prog #(
        .CNT_W(CNT_W), .DIV_DEFAULT(DIV_DEF), .WRAP(WRAP), .WRAP_W(WRAP_W)
    ) dut (
        .clk_2MHz(clk_2MHz),
        .reset(reset),
`ifdef TICK_SYNC_CLR_EN
        .sync_clr(sync_clr),
`endif
        .en(en),
        .div_load(div_load),
        .div_in(div_in),
        .tick(tick),
        .clk_out(clk_out),
        .wrap(wrap),
        .div_q(div_q)
    );

    always #5 clk_2MHz = ~clk_2MHz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_2MHz);
        #1;
    endtask

    // From a cleared state with divisor DIV_DEF: tick every 5, clk_out toggles per tick, wrap every 15.
    task automatic run_fresh(input int n);
        for (int k = 1; k <= n; k++) begin
            step();
            check("run_tick", 32'(tick),    32'((k % DIV_DEF) == 0));
            check("run_clk",  32'(clk_out), 32'((k / DIV_DEF) % 2));
            check("run_wrap", 32'(wrap),    32'((k % (DIV_DEF * WRAP)) == 0));
        end
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        div_load = 1'b0;
        div_in   = '0;
`ifdef TICK_SYNC_CLR_EN
        sync_clr = 1'b0;
`endif
        #2;
        check("rst_tick", 32'(tick),    32'd0);
        check("rst_clk",  32'(clk_out), 32'd0);
        check("rst_wrap", 32'(wrap),    32'd0);
        check("rst_div",  32'(div_q),   32'd5);

        @(negedge clk_2MHz);
        reset = 1'b0;
        en    = 1'b1;
        run_fresh(30);

        // Load 3 when cnt=3 under divisor 5; clk_out is high here.
        repeat (8) step();
        check("pre_load_clk",  32'(clk_out), 32'd1);
        check("pre_load_tick", 32'(tick),    32'd0);
        div_load = 1'b1;
        div_in   = 8'd3;
        step();
        div_load = 1'b0;
        check("load3_div",  32'(div_q),   32'd3);
        check("load3_tick", 32'(tick),    32'd0);
        check("load3_clk",  32'(clk_out), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("load3_period", 32'(tick), 32'(i == 3));
        end
        check("load3_clk_tog", 32'(clk_out), 32'd0);
        check("load3_nowrap",  32'(wrap),    32'd0);
        repeat (3) step();
        check("div3_tick", 32'(tick),    32'd1);
        check("div3_wrap", 32'(wrap),    32'd1);
        check("div3_clk",  32'(clk_out), 32'd1);

        // Divisors 0 and 1 clamp to 2.
        div_load = 1'b1;
        div_in   = 8'd0;
        step();
        check("load0_div",  32'(div_q), 32'd2);
        check("load0_tick", 32'(tick),  32'd0);
        div_in = 8'd1;
        step();
        check("load1_div", 32'(div_q), 32'd2);
        div_load = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("div2_tick", 32'(tick), 32'((i % 2) == 0));
            check("div2_wrap", 32'(wrap), 32'd0);
        end
        check("div2_clk", 32'(clk_out), 32'd1);

        // Divisor 5 with en low for 4 cycles at cnt=2: that period spans 9 cycles.
        div_load = 1'b1;
        div_in   = 8'd5;
        step();
        div_load = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            en = !(i >= 3 && i <= 6);
            step();
            check("gap_tick", 32'(tick), 32'(i == 9));
            check("gap_wrap", 32'(wrap), 32'(i == 9));
        end
        en = 1'b1;
        check("gap_clk", 32'(clk_out), 32'd0);

        // Async reset at cnt=4, wcnt=2 with divisor 6 loaded.
        div_load = 1'b1;
        div_in   = 8'd6;
        step();
        div_load = 1'b0;
        repeat (16) step();
        check("pre_rst_div",  32'(div_q), 32'd6);
        check("pre_rst_tick", 32'(tick),  32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_tick", 32'(tick),    32'd0);
        check("arst_clk",  32'(clk_out), 32'd0);
        check("arst_wrap", 32'(wrap),    32'd0);
        check("arst_div",  32'(div_q),   32'd5);
        step();
        check("arst_hold_tick", 32'(tick), 32'd0);
        check("arst_hold_wrap", 32'(wrap), 32'd0);
        @(negedge clk_2MHz);
        reset = 1'b0;
        run_fresh(15);

`ifdef TICK_SYNC_CLR_EN
        // clk_out is high here; sync_clr at cnt=2 restarts everything but the divisor.
        repeat (2) step();
        check("pre_sclr_clk", 32'(clk_out), 32'd1);
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        check("sclr_clk",  32'(clk_out), 32'd0);
        check("sclr_tick", 32'(tick),    32'd0);
        check("sclr_div",  32'(div_q),   32'd5);
        run_fresh(15);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
